// File: rtl/nibble_pack_stream.sv
// Packs selected nibbles of a byte stream into output bytes through a small output FIFO.
// Define NIBBLE_PACK_PARITY_EN to add a per-entry even-parity output (out_parity).
module nibble_pack_stream #(
    parameter int OUT_DEPTH = 2,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [7:0]                  in_data,
    input  logic                        sel_hi,
    input  logic                        flush,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [7:0]                  out_data,
    output logic                        out_partial,
`ifdef NIBBLE_PACK_PARITY_EN
    output logic                        out_parity,
`endif
    output logic [$clog2(OUT_DEPTH):0]  count
);

    localparam int AW = $clog2(OUT_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {EMPTY = 1'b0, HALF = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [3:0]      hold_q, hold_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      mem_data_q [OUT_DEPTH];
    logic            mem_part_q [OUT_DEPTH];
`ifdef NIBBLE_PACK_PARITY_EN
    logic            mem_par_q  [OUT_DEPTH];
`endif

    logic            accept;
    logic            pop;
    logic            push;
    logic [7:0]      push_data;
    logic            push_part;
    logic [3:0]      nib;

    assign in_ready  = (count_q != CW'(OUT_DEPTH));
    assign out_valid = (count_q != '0);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign nib       = sel_hi ? in_data[7:4] : in_data[3:0];
    assign count     = count_q;

    assign out_data    = out_valid ? mem_data_q[rd_ptr_q] : 8'h00;
    assign out_partial = out_valid ? mem_part_q[rd_ptr_q] : 1'b0;
`ifdef NIBBLE_PACK_PARITY_EN
    assign out_parity  = out_valid ? mem_par_q[rd_ptr_q] : 1'b0;
`endif

    // Packing FSM; a flush can only complete a partial byte when the FIFO has room.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        push      = 1'b0;
        push_data = 8'h00;
        push_part = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    hold_d  = nib;
                    state_d = HALF;
                end
            end
            HALF: begin
                if (accept) begin
                    push      = 1'b1;
                    push_data = MSB_FIRST ? {hold_q, nib} : {nib, hold_q};
                    state_d   = EMPTY;
                end else if (flush && in_ready) begin
                    push      = 1'b1;
                    push_data = MSB_FIRST ? {hold_q, 4'h0} : {4'h0, hold_q};
                    push_part = 1'b1;
                    state_d   = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            hold_q   <= 4'h0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) begin
                mem_data_q[i] <= 8'h00;
                mem_part_q[i] <= 1'b0;
`ifdef NIBBLE_PACK_PARITY_EN
                mem_par_q[i]  <= 1'b0;
`endif
            end
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) begin
                mem_data_q[wr_ptr_q] <= push_data;
                mem_part_q[wr_ptr_q] <= push_part;
`ifdef NIBBLE_PACK_PARITY_EN
                mem_par_q[wr_ptr_q]  <= ^push_data;
`endif
            end
        end
    end

endmodule

// File: tb/tb_nibble_pack_stream.sv
// Directed bench for nibble_pack_stream: MSB_FIRST=1 and MSB_FIRST=0 instances share stimulus.
module tb_nibble_pack_stream;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, sel_hi, flush, out_ready;
    logic [7:0] in_data;
    logic       in_ready0, in_ready1, out_valid0, out_valid1;
    logic [7:0] out_data0, out_data1;
    logic       out_partial0, out_partial1;
    logic [1:0] count0, count1;
`ifdef NIBBLE_PACK_PARITY_EN
    logic       par0, par1;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    nibble_pack_stream #(.OUT_DEPTH(2), .MSB_FIRST(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .sel_hi(sel_hi), .flush(flush),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .out_partial(out_partial0),
`ifdef NIBBLE_PACK_PARITY_EN
        .out_parity(par0),
`endif
        .count(count0)
    );

    nibble_pack_stream #(.OUT_DEPTH(2), .MSB_FIRST(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .sel_hi(sel_hi), .flush(flush),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .out_partial(out_partial1),
`ifdef NIBBLE_PACK_PARITY_EN
        .out_parity(par1),
`endif
        .count(count1)
    );

    typedef struct {
        logic [7:0] d0;
        logic       s0;
        logic [7:0] d1;
        logic       s1;
        logic [7:0] exp_msb;
        logic [7:0] exp_lsb;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] d, input logic s);
        in_valid = 1'b1;
        in_data  = d;
        sel_hi   = s;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 8'h3C, 1'b1, 8'h53, 8'h35};
        vecs[1] = '{8'hF0, 1'b1, 8'h0F, 1'b0, 8'hFF, 8'hFF};
        vecs[2] = '{8'h12, 1'b1, 8'h34, 1'b0, 8'h14, 8'h41};
        vecs[3] = '{8'h80, 1'b1, 8'h01, 1'b0, 8'h81, 8'h18};
        vecs[4] = '{8'h00, 1'b0, 8'hBE, 1'b1, 8'h0B, 8'hB0};

        rst_n = 1'b0; in_valid = 1'b0; sel_hi = 1'b0; flush = 1'b0;
        out_ready = 1'b0; in_data = 8'h00;
        #2;
        chk("rst_out_valid", 32'(out_valid0), 0);
        chk("rst_out_data", 32'(out_data0), 0);
        chk("rst_out_partial", 32'(out_partial0), 0);
        chk("rst_count", 32'(count0), 0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_in_ready", 32'(in_ready0), 1);
        chk("post_rst_count", 32'(count0), 0);

        // Table-driven packing, consumer always ready
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            put(vecs[i].d0, vecs[i].s0);
            chk($sformatf("v%0d_after1_valid", i), 32'(out_valid0), 0);
            put(vecs[i].d1, vecs[i].s1);
            chk($sformatf("v%0d_valid", i), 32'(out_valid0), 1);
            chk($sformatf("v%0d_data_msb", i), 32'(out_data0), 32'(vecs[i].exp_msb));
            chk($sformatf("v%0d_data_lsb", i), 32'(out_data1), 32'(vecs[i].exp_lsb));
            chk($sformatf("v%0d_partial", i), 32'(out_partial0), 0);
            chk($sformatf("v%0d_partial_lsb", i), 32'(out_partial1), 0);
            chk($sformatf("v%0d_count", i), 32'(count0), 1);
`ifdef NIBBLE_PACK_PARITY_EN
            chk($sformatf("v%0d_parity", i), 32'(par0), 32'(^vecs[i].exp_msb));
`endif
            step();
            chk($sformatf("v%0d_drained", i), 32'(out_valid0), 0);
        end

        // Flush of a held nibble, then flush coinciding with accept
        out_ready = 1'b0;
        put(8'h09, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_data", 32'(out_data0), 32'h90);
        chk("flush_data_lsb", 32'(out_data1), 32'h09);
        chk("flush_partial", 32'(out_partial0), 1);
        chk("flush_count", 32'(count0), 1);
`ifdef NIBBLE_PACK_PARITY_EN
        chk("flush_parity", 32'(par0), 0);
`endif
        put(8'h90, 1'b1);
        flush = 1'b1;
        put(8'h07, 1'b0);
        flush = 1'b0;
        chk("flush_acc_count", 32'(count0), 2);
        chk("flush_acc_in_ready", 32'(in_ready0), 0);
        chk("flush_acc_head_stable", 32'(out_data0), 32'h90);
        out_ready = 1'b1;
        step();
        chk("flush_acc_data", 32'(out_data0), 32'h97);
        chk("flush_acc_data_lsb", 32'(out_data1), 32'h79);
        chk("flush_acc_partial", 32'(out_partial0), 0);
`ifdef NIBBLE_PACK_PARITY_EN
        chk("flush_acc_parity", 32'(par0), 1);
`endif
        step();
        chk("flush_acc_drained", 32'(count0), 0);

        // Flush while EMPTY is ignored
        out_ready = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_empty_count", 32'(count0), 0);
        chk("flush_empty_valid", 32'(out_valid0), 0);

        // Fill FIFO; flush and input ignored while full; pop frees space next cycle
        put(8'h11, 1'b1);
        put(8'h22, 1'b0);
        put(8'h33, 1'b1);
        put(8'h44, 1'b0);
        chk("full_count", 32'(count0), 2);
        chk("full_in_ready", 32'(in_ready0), 0);
        in_valid = 1'b1; in_data = 8'h55; sel_hi = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0;
        chk("full_flush_count", 32'(count0), 2);
        chk("full_head", 32'(out_data0), 32'h12);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("pop_count", 32'(count0), 1);
        chk("pop_in_ready", 32'(in_ready0), 1);
        chk("pop_head", 32'(out_data0), 32'h34);
        step();
        in_data = 8'h66; sel_hi = 1'b0;
        step();
        in_valid = 1'b0;
        chk("refill_count", 32'(count0), 2);
        out_ready = 1'b1;
        step();
        chk("refill_head", 32'(out_data0), 32'h56);
        chk("refill_head_lsb", 32'(out_data1), 32'h65);
        step();
        chk("refill_drained", 32'(count0), 0);

        // Reset mid-stream while HALF with one byte queued
        out_ready = 1'b0;
        put(8'hAA, 1'b1);
        put(8'hBB, 1'b1);
        put(8'hCC, 1'b1);
        chk("pre_rst_count", 32'(count0), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_count", 32'(count0), 0);
        chk("midrst_valid", 32'(out_valid0), 0);
        chk("midrst_data", 32'(out_data0), 0);
        #2;
        rst_n = 1'b1;
        step();
        put(8'hA5, 1'b0);
        chk("midrst_first_valid", 32'(out_valid0), 0);
        put(8'h3C, 1'b1);
        chk("midrst_pack", 32'(out_data0), 32'h53);
        chk("midrst_pack_count", 32'(count0), 1);
        chk("midrst_pack_partial", 32'(out_partial0), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
